// File: rtl/transducer_array_pkg.sv
`default_nettype none
// transducer_array_pkg: shared state encoding and timebase derivation helpers.
// Rev 1.0
package transducer_array_pkg;

    localparam int STATE_W = 2;
    localparam logic [1:0] ST_UNLOCKED     = 2'd0;
    localparam logic [1:0] ST_MASTER_RUN   = 2'd1;
    localparam logic [1:0] ST_SLAVE_LOCKED = 2'd2;

    // A slave sees the master's cnt==0 three clocks late (two sync flops + edge register).
    localparam int SYNC_LATENCY = 3;

    function automatic int calc_period(input int clk_freq, input int out_freq);
        return clk_freq / out_freq;
    endfunction

    function automatic int calc_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/transducer_array_sync_detect.sv
`default_nettype none
// transducer_array_sync_detect: sync_in synchronizer, rising-edge detect and lock watchdog.
// Rev 1.0
module transducer_array_sync_detect
    import transducer_array_pkg::*;
#(
    parameter int PERIOD   = 256,
    parameter int LOCK_TOL = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic sync_i,
    output logic edge_o,
    output logic in_window_o,
    output logic timeout_o
);

    localparam int LIMIT  = PERIOD + LOCK_TOL;
    localparam int WIN_LO = (PERIOD > LOCK_TOL) ? PERIOD - LOCK_TOL : 0;
    localparam int CNT_W  = calc_width(LIMIT + 2);

    logic             s1_q, s2_q, s3_q;
    logic             seen_q;
    logic [CNT_W-1:0] since_q, since_d;

    assign edge_o = s2_q & ~s3_q;

    // since_q holds the tick distance to the previous edge; it saturates one past the window.
    always_comb begin
        since_d = since_q;
        if (edge_o) begin
            since_d = CNT_W'(1);
        end else if (since_q != CNT_W'(LIMIT + 1)) begin
            since_d = since_q + CNT_W'(1);
        end
    end

    assign in_window_o = seen_q && (since_q >= CNT_W'(WIN_LO)) && (since_q <= CNT_W'(LIMIT));
    assign timeout_o   = seen_q && !edge_o && (since_q == CNT_W'(LIMIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            seen_q  <= 1'b0;
            since_q <= '0;
        end else begin
            s1_q    <= sync_i;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            seen_q  <= seen_q | edge_o;
            since_q <= since_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/transducer_array.sv
`default_nettype none
// transducer_array: phase-programmable multi-channel transducer drive with master/slave timebase.
// Rev 1.0
module transducer_array
    import transducer_array_pkg::*;
#(
    parameter int CLK_FREQ     = 10_240_000,
    parameter int OUT_FREQ     = 40_000,
    parameter int NUM_CHANNELS = 2,
    parameter int DUTY         = calc_period(CLK_FREQ, OUT_FREQ) / 2,
    parameter int SYNC_W       = 4,
    parameter int LOCK_TOL     = 16,
    localparam int PERIOD      = calc_period(CLK_FREQ, OUT_FREQ),
    localparam int PHASE_W     = calc_width(PERIOD),
    localparam int ADDR_W      = calc_width(NUM_CHANNELS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    master_i,
    input  logic                    enable_i,
    input  logic                    sync_in_i,
    input  logic                    ph_wr_i,
    input  logic [ADDR_W-1:0]       ph_addr_i,
    input  logic [PHASE_W-1:0]      ph_data_i,
    input  logic                    commit_i,
    output logic [NUM_CHANNELS-1:0] trans_o,
    output logic                    sync_out_o,
    output logic                    locked_o,
    output logic                    commit_pending_o,
    output logic                    wr_err_o
);

    localparam int EXT_W = PHASE_W + 1;

    logic [STATE_W-1:0]      state_q, state_d;
    logic [PHASE_W-1:0]      cnt_q, cnt_d;
    logic                    sync_out_q, sync_out_d;
    logic [NUM_CHANNELS-1:0] trans_q, trans_d;
    logic                    pending_q, pending_d;
    logic                    wr_err_q;

    logic sync_edge_w, in_window_w, timeout_w;
    logic locked_w, wr_valid_w, transfer_w, wrap_w;

    transducer_array_sync_detect #(
        .PERIOD   (PERIOD),
        .LOCK_TOL (LOCK_TOL)
    ) u_sync_detect (
        .clk         (clk),
        .rst         (rst),
        .sync_i      (sync_in_i),
        .edge_o      (sync_edge_w),
        .in_window_o (in_window_w),
        .timeout_o   (timeout_w)
    );

    assign locked_w   = (state_q != ST_UNLOCKED);
    assign wrap_w     = (cnt_q == PHASE_W'(PERIOD - 1));
    assign wr_valid_w = (int'(ph_addr_i) < NUM_CHANNELS) && (int'(ph_data_i) < PERIOD);
    // A commit arriving on the wrap edge itself is honoured immediately.
    assign transfer_w = wrap_w && (pending_q || commit_i);
    assign pending_d  = transfer_w ? 1'b0 : (pending_q | commit_i);

    always_comb begin
        state_d = state_q;
        if (master_i) begin
            state_d = ST_MASTER_RUN;
        end else begin
            case (state_q)
                ST_MASTER_RUN:   state_d = ST_UNLOCKED;
                ST_UNLOCKED:     if (sync_edge_w && in_window_w) state_d = ST_SLAVE_LOCKED;
                ST_SLAVE_LOCKED: if (timeout_w) state_d = ST_UNLOCKED;
                default:         state_d = ST_UNLOCKED;
            endcase
        end
    end

    always_comb begin
        cnt_d = wrap_w ? '0 : cnt_q + PHASE_W'(1);
        if (!master_i && sync_edge_w) begin
            cnt_d = PHASE_W'(SYNC_LATENCY);
        end
        sync_out_d = (state_d == ST_MASTER_RUN) && (int'(cnt_d) < SYNC_W);
    end

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        logic [PHASE_W-1:0] shadow_q;
        logic [PHASE_W-1:0] active_q;
        logic [EXT_W-1:0]   cnt_ext_w, ph_ext_w, dist_w;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                shadow_q <= '0;
                active_q <= '0;
            end else begin
                if (ph_wr_i && wr_valid_w && (ph_addr_i == ADDR_W'(i))) begin
                    shadow_q <= ph_data_i;
                end
                if (transfer_w) begin
                    active_q <= shadow_q;
                end
            end
        end

        // Distance from the channel's phase, taken modulo PERIOD without a divider.
        assign cnt_ext_w = {1'b0, cnt_q};
        assign ph_ext_w  = {1'b0, active_q};
        assign dist_w    = (cnt_ext_w >= ph_ext_w) ? (cnt_ext_w - ph_ext_w)
                                                   : (cnt_ext_w + EXT_W'(PERIOD) - ph_ext_w);
        assign trans_d[i] = enable_i && locked_w && (dist_w < EXT_W'(DUTY));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_UNLOCKED;
            cnt_q      <= '0;
            sync_out_q <= 1'b0;
            trans_q    <= '0;
            pending_q  <= 1'b0;
            wr_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sync_out_q <= sync_out_d;
            trans_q    <= trans_d;
            pending_q  <= pending_d;
            wr_err_q   <= ph_wr_i & ~wr_valid_w;
        end
    end

    assign trans_o          = trans_q;
    assign sync_out_o       = sync_out_q;
    assign locked_o         = locked_w;
    assign commit_pending_o = pending_q;
    assign wr_err_o         = wr_err_q;

endmodule
`default_nettype wire
